// File: rtl/lapido_fetch_pkg.sv
// Shared fetch-stage types and constants for the core_lapido datapath.
// Imported by fetch, decode and instruction-memory blocks.
package lapido_fetch_pkg;

    localparam int unsigned LAPIDO_ADDR_W   = 32;
    localparam int unsigned LAPIDO_DATA_W   = 32;
    localparam int unsigned LAPIDO_RESET_PC = 32'd0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_HOLD = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_stage_pc_unit.sv
// Program counter register with the sequential / redirect next-PC mux.
// Word addressing: the sequential successor is pc + 1, wrapping silently.
module pc_unit
    import lapido_fetch_pkg::*;
#(
    parameter int unsigned ADDR_W   = LAPIDO_ADDR_W,
    parameter int unsigned RESET_PC = LAPIDO_RESET_PC
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              commit,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_addr,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus1
);

    logic [ADDR_W-1:0] pc_r;
    logic [ADDR_W-1:0] pc_next_s;

    // Sequential successor and branch/jump target selection.
    always_comb begin
        pc_plus1 = pc_r + {{(ADDR_W-1){1'b0}}, 1'b1};
        if (redirect) begin
            pc_next_s = redirect_addr;
        end else begin
            pc_next_s = pc_plus1;
        end
    end

    // PC register, updated only on a commit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_r <= RESET_PC[ADDR_W-1:0];
        end else if (commit) begin
            pc_r <= pc_next_s;
        end else begin
            pc_r <= pc_r;
        end
    end

    assign pc = pc_r;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC ownership, imem request/ready handshake and
// instruction register feeding decode.
module fetch_stage
    import lapido_fetch_pkg::*;
#(
    parameter int unsigned ADDR_W   = LAPIDO_ADDR_W,
    parameter int unsigned DATA_W   = LAPIDO_DATA_W,
    parameter int unsigned RESET_PC = LAPIDO_RESET_PC
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_enable,
    input  logic              pc_write,
    input  logic              stall,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_addr,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_rdata,
    input  logic              imem_ready,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus1,
    output logic [DATA_W-1:0] instr,
    output logic              instr_valid,
    output logic              fetch_overrun
);

    fetch_state_e      state_r, state_nxt_s;
    logic              commit_pending_r, commit_pending_nxt_s;
    logic [DATA_W-1:0] instr_r, instr_nxt_s;
    logic              instr_valid_r, instr_valid_nxt_s;
    logic              imem_req_r, imem_req_nxt_s;
    logic              fetch_overrun_r, fetch_overrun_nxt_s;
    logic              commit_ok_s;
    logic              commit_s;
    logic [ADDR_W-1:0] pc_s;

    assign commit_ok_s = pc_write & ~stall;

    pc_unit #(
        .ADDR_W  (ADDR_W),
        .RESET_PC(RESET_PC)
    ) u_pc_unit (
        .clk          (clk),
        .rst_n        (rst_n),
        .commit       (commit_s),
        .redirect     (redirect),
        .redirect_addr(redirect_addr),
        .pc           (pc_s),
        .pc_plus1     (pc_plus1)
    );

    // Next-state, commit and datapath-register decisions.
    always_comb begin
        state_nxt_s          = state_r;
        commit_pending_nxt_s = commit_pending_r;
        instr_nxt_s          = instr_r;
        instr_valid_nxt_s    = instr_valid_r;
        imem_req_nxt_s       = imem_req_r;
        fetch_overrun_nxt_s  = fetch_overrun_r;
        commit_s             = 1'b0;

        case (state_r)
            ST_IDLE: begin
                // A commit here lands before the fetch, so the fetch sees the new PC.
                commit_s = commit_ok_s;
                if (if_enable) begin
                    state_nxt_s       = ST_REQ;
                    imem_req_nxt_s    = 1'b1;
                    instr_valid_nxt_s = 1'b0;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (if_enable) begin
                    fetch_overrun_nxt_s = 1'b1;
                end else begin
                    fetch_overrun_nxt_s = fetch_overrun_r;
                end
                if (imem_ready) begin
                    instr_nxt_s       = imem_rdata;
                    instr_valid_nxt_s = 1'b1;
                    imem_req_nxt_s    = 1'b0;
                    if (commit_pending_r || commit_ok_s) begin
                        commit_s             = 1'b1;
                        commit_pending_nxt_s = 1'b0;
                        state_nxt_s          = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_HOLD;
                    end
                end else if (commit_ok_s) begin
                    commit_pending_nxt_s = 1'b1;
                end else begin
                    commit_pending_nxt_s = commit_pending_r;
                end
            end
            ST_HOLD: begin
                if (if_enable) begin
                    fetch_overrun_nxt_s = 1'b1;
                end else begin
                    fetch_overrun_nxt_s = fetch_overrun_r;
                end
                if (commit_ok_s) begin
                    commit_s    = 1'b1;
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_HOLD;
                end
            end
            default: begin
                state_nxt_s          = ST_IDLE;
                imem_req_nxt_s       = 1'b0;
                commit_pending_nxt_s = 1'b0;
            end
        endcase
    end

    // Control and instruction registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r          <= ST_IDLE;
            commit_pending_r <= 1'b0;
            instr_r          <= {DATA_W{1'b0}};
            instr_valid_r    <= 1'b0;
            imem_req_r       <= 1'b0;
            fetch_overrun_r  <= 1'b0;
        end else begin
            state_r          <= state_nxt_s;
            commit_pending_r <= commit_pending_nxt_s;
            instr_r          <= instr_nxt_s;
            instr_valid_r    <= instr_valid_nxt_s;
            imem_req_r       <= imem_req_nxt_s;
            fetch_overrun_r  <= fetch_overrun_nxt_s;
        end
    end

    assign imem_req      = imem_req_r;
    assign imem_addr     = pc_s;
    assign pc            = pc_s;
    assign instr         = instr_r;
    assign instr_valid   = instr_valid_r;
    assign fetch_overrun = fetch_overrun_r;

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the multicycle core_lapido datapath. Owns the program counter and instruction register. Consumes the `if_enable` / `pc_write` pulse pair produced by the clock-phase counter, runs a request/ready handshake with instruction memory, and latches the fetched word for decode. Sits between the clock-phase counter (upstream control) and the decode stage (downstream data).

## Interface

Parameters:

- `ADDR_W`, default 32: PC and memory address width.
- `DATA_W`, default 32: instruction width.
- `RESET_PC`, default 0: PC value after reset.

Ports:

- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `if_enable`  in  1  one-cycle pulse that starts a fetch.
- `pc_write`  in  1  one-cycle pulse that commits the next PC.
- `stall`  in  1  suppresses the PC commit while high.
- `redirect`  in  1  next PC comes from `redirect_addr` (branch or jump).
- `redirect_addr`  in  ADDR_W  redirect target, word address.
- `imem_req`  out  1  memory request, registered.
- `imem_addr`  out  ADDR_W  request address; equals `pc`.
- `imem_rdata`  in  DATA_W  memory read data, valid when `imem_ready` is high.
- `imem_ready`  in  1  memory response strobe.
- `pc`  out  ADDR_W  current PC.
- `pc_plus1`  out  ADDR_W  `pc + 1`, combinational, for link and branch arithmetic.
- `instr`  out  DATA_W  latched instruction.
- `instr_valid`  out  1  `instr` holds the word fetched from the current `pc`.
- `fetch_overrun`  out  1  sticky flag: `if_enable` arrived while a fetch was still active.

## Operation

Reset values (`rst_n` low, asynchronous):

- `pc = RESET_PC`
- `instr = 0`
- `instr_valid = 0`
- `imem_req = 0`
- `fetch_overrun = 0`
- state = IDLE
- `commit_pending = 0`

Addressing is by word, so the sequential next PC is `pc + 1`. It wraps modulo 2^ADDR_W with no flag.

Next PC is `redirect ? redirect_addr : pc + 1`. It is sampled in the cycle the commit takes effect.

FSM states:

- **IDLE**
  - `if_enable` → REQ. Set `imem_req` = 1 and clear `instr_valid`.
- **REQ** (`imem_req` = 1)
  - `imem_ready` with `commit_pending` = 0 → HOLD. Latch `instr <= imem_rdata`, set `instr_valid`, drop `imem_req`.
  - `imem_ready` with `commit_pending` = 1 → IDLE. Latch `instr`, set `instr_valid`, commit the PC in the same edge, clear `commit_pending`.
  - `pc_write` and `!stall` while `imem_ready` is low → set `commit_pending`. The PC does not change yet.
- **HOLD**
  - `pc_write` and `!stall` → IDLE. `pc <= next PC`. `instr` and `instr_valid` are held.

Stall behaviour:

- `pc_write` while `stall` is high is dropped in every state: no commit and no pending flag.
- The PC stays unchanged until a later `pc_write` arrives with `stall` low.

Overrun behaviour:

- `if_enable` in REQ or HOLD is ignored and sets `fetch_overrun`.
- `fetch_overrun` clears only on reset.

`pc_write` in IDLE is a legal commit: `pc` updates and the state stays IDLE. This covers a re-issue after a stall.

Simultaneous events:

- `if_enable` and `pc_write` in the same IDLE cycle: commit first, and the fetch uses the new PC (`imem_addr` equals the new `pc` next cycle).
- `imem_ready` and `pc_write` in the same REQ cycle: treated as the pending case; go directly to IDLE with the commit.

Reset mid-fetch: `imem_req` drops immediately (asynchronously). Any late `imem_ready` after release is ignored in IDLE.

## Timing

With the fetch pulse at cycle T (`if_enable` high during cycle T):

- `imem_req` is high from T+1.
- With zero-wait memory (`imem_ready` in T+1), `instr_valid` is high from T+2.
- Commit pulse at T+4 (`pc_write` high during T+4) → new `pc` visible at T+5.
- Each memory wait cycle delays `instr_valid` by one cycle.
- The commit is delayed only when `imem_ready` comes after `pc_write`; the PC then updates on the `imem_ready` edge.
- `imem_ready` is sampled only in REQ.

## Structure

- Shared package `lapido_fetch_pkg` holds:
  - the state enum (IDLE, REQ, HOLD);
  - the default `RESET_PC`;
  - the address and data width constants shared with decode and memory.
- The PC register and next-PC mux form one natural sub-module, `pc_unit`: inputs `commit`, `redirect`, `redirect_addr`; outputs `pc` and `pc_plus1`.
- The FSM, pending flag, and instruction register stay in the top level.

## Test plan

1. **Reset then nominal cycle.** Release `rst_n` with `RESET_PC=0`, `if_enable` every 5 cycles, `pc_write` 4 cycles after each, zero-wait memory returning `0xA0+addr` → `instr` takes 0xA0, 0xA1, 0xA2 and `pc` takes 0, 1, 2, 3 at T+5 of each fetch.
2. **Redirect.** `redirect=1`, `redirect_addr=0x40` at `pc_write` → `pc=0x40`. The next fetch drives `imem_addr=0x40`.
3. **Slow memory.** `imem_ready` arrives 6 cycles after `imem_req`, after `pc_write` → `pc` updates on the `imem_ready` edge. `instr_valid=1` with the correct word, and the state returns to IDLE.
4. **Stall.** `stall=1` during `pc_write` → `pc` unchanged and `commit_pending` stays 0. The next `pc_write` with `stall=0` commits `pc+1`.
5. **Overrun and wrap.** `if_enable` pulsed while in REQ → `fetch_overrun=1`, which stays set. Separately, with `pc=2^ADDR_W-1`, a commit → `pc=0`.
6. **Reset mid-fetch.** Assert `rst_n` low while in REQ → `imem_req=0` and `pc=RESET_PC` without waiting for a clock. A late `imem_ready` after release leaves `instr_valid=0`.
